// File: rtl/id_stage_ctrl_pkg.sv
// Shared types for the decode-stage sequencer: fetch entries, scoreboard entries,
// exception causes, functional units and the sequencer state.
package id_stage_ctrl_pkg;

  // trans_id width is fixed here; a module NR_SB_ENTRIES must not exceed 2**TRANS_ID_BITS.
  localparam int unsigned NR_SB_ENTRIES_DFLT = 8;
  localparam int unsigned TRANS_ID_BITS      = $clog2(NR_SB_ENTRIES_DFLT);

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [3:0] INSTR_ACCESS_FAULT = 4'd1;
  localparam logic [3:0] ILLEGAL_INSTR      = 4'd2;
  localparam logic [3:0] BREAKPOINT         = 4'd3;
  localparam logic [3:0] ENV_CALL_UMODE     = 4'd8;
  localparam logic [3:0] ENV_CALL_SMODE     = 4'd9;
  localparam logic [3:0] ENV_CALL_MMODE     = 4'd11;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_lvl_t;

  typedef enum logic [2:0] {
    FU_NONE,
    FU_ALU,
    FU_BRANCH,
    FU_LOAD,
    FU_STORE,
    FU_CSR
  } fu_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_LUI, OP_AUIPC, OP_JUMP, OP_BRANCH, OP_MEM, OP_SYS
  } op_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cause;
    logic [31:0] tval;
  } exception_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    exception_t  ex;
  } fetch_entry_t;

  typedef struct packed {
    logic                     valid;
    logic [31:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    op_t                      op;
    logic [6:0]               opcode;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [31:0]              imm;
    logic                     use_imm;
    logic                     use_pc;
    exception_t               ex;
  } scoreboard_entry_t;

  typedef enum logic [1:0] {
    RUN,
    SERIAL,
    HALT
  } idc_state_e;

  function automatic logic is_serializing(input scoreboard_entry_t sbe);
    return (sbe.fu == FU_CSR) || (sbe.opcode == OPCODE_SYSTEM);
  endfunction

endpackage

// File: rtl/id_stage_ctrl_if.sv
// Fetch-side and issue-side handshake bundle of the decode-stage sequencer.
interface id_stage_ctrl_if;
  import id_stage_ctrl_pkg::*;

  // Both sides are valid/ready: a fetch transfer happens on a cycle with
  // fetch_valid_i && fetch_ready_o; an issue transfer on issue_valid_o && issue_ack_i.
  // issue_sbe_o must stay bit-stable while issue_valid_o && !issue_ack_i.
  logic              fetch_valid_i;
  fetch_entry_t      fetch_entry_i;
  logic              fetch_ready_o;
  logic              issue_valid_o;
  scoreboard_entry_t issue_sbe_o;
  logic              issue_ack_i;

  modport slave (
    input  fetch_valid_i, fetch_entry_i, issue_ack_i,
    output fetch_ready_o, issue_valid_o, issue_sbe_o
  );

  modport master (
    output fetch_valid_i, fetch_entry_i, issue_ack_i,
    input  fetch_ready_o, issue_valid_o, issue_sbe_o
  );

endinterface

// File: rtl/id_stage_ctrl_decoder.sv
// Combinational RV32I/Zicsr decoder producing a scoreboard entry from one fetch entry.
module id_stage_ctrl_decoder
  import id_stage_ctrl_pkg::*;
(
  input  logic              valid,
  input  fetch_entry_t      entry,
  input  priv_lvl_t         priv_lvl,
  input  logic              debug_mode,
  input  logic              tvm,
  input  logic              tw,
  input  logic              tsr,
  output scoreboard_entry_t sbe
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal, ecall, ebreak;

  assign instr  = entry.instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  function automatic op_t alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  always_comb begin
    sbe         = '0;
    illegal     = 1'b0;
    ecall       = 1'b0;
    ebreak      = 1'b0;
    sbe.valid   = valid;
    sbe.pc      = entry.pc;
    sbe.opcode  = opcode;
    sbe.rs1     = instr[19:15];
    sbe.rs2     = instr[24:20];
    sbe.rd      = instr[11:7];

    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPCODE_OP_IMM: begin
          sbe.fu      = FU_ALU;
          sbe.op      = alu_op(funct3, funct7[5] && (funct3 == 3'b101));
          sbe.imm     = imm_i;
          sbe.use_imm = 1'b1;
          sbe.rs2     = '0;
          if ((funct3 == 3'b001 && funct7 != 7'b0) ||
              (funct3 == 3'b101 && (funct7 & 7'b1011111) != 7'b0)) illegal = 1'b1;
        end
        OPCODE_OP: begin
          sbe.fu = FU_ALU;
          sbe.op = alu_op(funct3, funct7[5]);
          if (funct7 != 7'b0 &&
              !(funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) illegal = 1'b1;
        end
        OPCODE_LUI, OPCODE_AUIPC: begin
          sbe.fu      = FU_ALU;
          sbe.op      = (opcode == OPCODE_LUI) ? OP_LUI : OP_AUIPC;
          sbe.imm     = imm_u;
          sbe.use_imm = 1'b1;
          sbe.use_pc  = (opcode == OPCODE_AUIPC);
          sbe.rs1     = '0;
          sbe.rs2     = '0;
        end
        OPCODE_JAL: begin
          sbe.fu      = FU_BRANCH;
          sbe.op      = OP_JUMP;
          sbe.imm     = imm_j;
          sbe.use_pc  = 1'b1;
          sbe.rs1     = '0;
          sbe.rs2     = '0;
        end
        OPCODE_JALR: begin
          sbe.fu      = FU_BRANCH;
          sbe.op      = OP_JUMP;
          sbe.imm     = imm_i;
          sbe.rs2     = '0;
          illegal     = (funct3 != 3'b000);
        end
        OPCODE_BRANCH: begin
          sbe.fu      = FU_BRANCH;
          sbe.op      = OP_BRANCH;
          sbe.imm     = imm_b;
          sbe.rd      = '0;
          illegal     = (funct3 == 3'b010) || (funct3 == 3'b011);
        end
        OPCODE_LOAD: begin
          sbe.fu      = FU_LOAD;
          sbe.op      = OP_MEM;
          sbe.imm     = imm_i;
          sbe.rs2     = '0;
          illegal     = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        OPCODE_STORE: begin
          sbe.fu      = FU_STORE;
          sbe.op      = OP_MEM;
          sbe.imm     = imm_s;
          sbe.rd      = '0;
          illegal     = (funct3 > 3'b010);
        end
        OPCODE_MISC_MEM: begin
          sbe.fu      = FU_NONE;
        end
        OPCODE_SYSTEM: begin
          sbe.op = OP_SYS;
          if (funct3 == 3'b100) begin
            illegal = 1'b1;
          end else if (funct3 != 3'b000) begin
            // CSR address travels in imm so the CSR unit needs no extra field.
            sbe.fu  = FU_CSR;
            sbe.imm = {20'b0, instr[31:20]};
          end else begin
            sbe.fu = FU_NONE;
            case (instr[31:20])
              12'h000: ecall   = 1'b1;
              12'h001: ebreak  = 1'b1;
              12'h302: illegal = (priv_lvl != PRIV_M);
              12'h102: illegal = (priv_lvl == PRIV_U) || (tsr && priv_lvl == PRIV_S);
              12'h105: illegal = tw && (priv_lvl != PRIV_M);
              12'h7b2: illegal = !debug_mode;
              default: begin
                if (funct7 == 7'b0001001)
                  illegal = (priv_lvl == PRIV_U) || (tvm && priv_lvl == PRIV_S);
                else
                  illegal = 1'b1;
              end
            endcase
          end
        end
        default: illegal = 1'b1;
      endcase
    end

    // Fetch faults outrank decode faults; decode faults outrank environment traps.
    if (entry.ex.valid) begin
      sbe.ex = entry.ex;
    end else if (illegal) begin
      sbe.ex = '{valid: 1'b1, cause: ILLEGAL_INSTR, tval: instr};
    end else if (ecall) begin
      sbe.ex.valid = 1'b1;
      case (priv_lvl)
        PRIV_U:  sbe.ex.cause = ENV_CALL_UMODE;
        PRIV_S:  sbe.ex.cause = ENV_CALL_SMODE;
        default: sbe.ex.cause = ENV_CALL_MMODE;
      endcase
    end else if (ebreak) begin
      sbe.ex = '{valid: 1'b1, cause: BREAKPOINT, tval: entry.pc};
    end
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage sequencer: fetch-entry FIFO, one decoder, registered issue entry,
// scoreboard index assignment and serialization of CSR/SYSTEM/excepting instructions.
module id_stage_ctrl
  import id_stage_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned NR_SB_ENTRIES = NR_SB_ENTRIES_DFLT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  id_stage_ctrl_if.slave        bus,
  input  priv_lvl_t             priv_lvl_i,
  input  logic                  debug_mode_i,
  input  logic                  tvm_i,
  input  logic                  tw_i,
  input  logic                  tsr_i,
  input  logic                  serialize_done_i,
  output logic                  busy_o,
  output idc_state_e            state_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [TRANS_ID_BITS-1:0] IDX_LAST = TRANS_ID_BITS'(NR_SB_ENTRIES - 1);

  fetch_entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr, wr_ptr;
  logic [PTR_W:0]           cnt;
  logic                     fifo_full, fifo_empty;
  logic                     push, load;
  logic [TRANS_ID_BITS-1:0] idx_cnt;
  idc_state_e               state_q, state_d;
  scoreboard_entry_t        dec_sbe, load_sbe;

  assign fifo_full         = (cnt == FIFO_FULL_CNT);
  assign fifo_empty        = (cnt == '0);
  assign bus.fetch_ready_o = !fifo_full && !flush_i;
  assign push              = bus.fetch_valid_i && bus.fetch_ready_o;
  assign load              = (state_q == RUN) && !fifo_empty && !flush_i &&
                             (!bus.issue_valid_o || bus.issue_ack_i);
  assign busy_o            = (state_q != RUN);
  assign state_o           = state_q;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= bus.fetch_entry_i;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  id_stage_ctrl_decoder u_decoder (
    .valid      (!fifo_empty),
    .entry      (mem[rd_ptr]),
    .priv_lvl   (priv_lvl_i),
    .debug_mode (debug_mode_i),
    .tvm        (tvm_i),
    .tw         (tw_i),
    .tsr        (tsr_i),
    .sbe        (dec_sbe)
  );

  always_comb begin
    load_sbe          = dec_sbe;
    load_sbe.trans_id = idx_cnt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus.issue_valid_o <= 1'b0;
      bus.issue_sbe_o   <= '0;
    end else if (flush_i) begin
      bus.issue_valid_o <= 1'b0;
    end else if (load) begin
      bus.issue_valid_o <= 1'b1;
      bus.issue_sbe_o   <= load_sbe;
    end else if (bus.issue_ack_i) begin
      bus.issue_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      idx_cnt <= '0;
    end else if (load) begin
      idx_cnt <= (idx_cnt == IDX_LAST) ? '0 : idx_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) state_q <= RUN;
    else                    state_q <= state_d;
  end

  // An excepting entry halts even when it would also serialize.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (load) begin
          if (dec_sbe.ex.valid)             state_d = HALT;
          else if (is_serializing(dec_sbe)) state_d = SERIAL;
        end
      end
      SERIAL: begin
        if (serialize_done_i && !bus.issue_valid_o) state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed self-checking bench for the decode-stage sequencer.
module tb_id_stage_ctrl;
  import id_stage_ctrl_pkg::*;

  localparam logic [31:0] I_ADDI  = 32'h00100093;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_CSRRW = 32'h300110F3;
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

  logic       clk;
  logic       rst_n;
  logic       flush;
  priv_lvl_t  priv_lvl;
  logic       debug_mode, tvm, tw, tsr;
  logic       serialize_done;
  logic       busy;
  idc_state_e state;
  int         checks;
  int         errors;

  id_stage_ctrl_if bus ();

  id_stage_ctrl #(.FIFO_DEPTH(2), .NR_SB_ENTRIES(8)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .bus              (bus),
    .priv_lvl_i       (priv_lvl),
    .debug_mode_i     (debug_mode),
    .tvm_i            (tvm),
    .tw_i             (tw),
    .tsr_i            (tsr),
    .serialize_done_i (serialize_done),
    .busy_o           (busy),
    .state_o          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] pc, input logic [31:0] instr);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_entry_i = '{pc: pc, instr: instr, ex: '0};
  endtask

  task automatic idle_fetch();
    bus.fetch_valid_i = 1'b0;
    bus.fetch_entry_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    serialize_done = 1'b0;
    bus.issue_ack_i = 1'b0;
    idle_fetch();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.issue_valid_o !== 1'b0 || bus.issue_sbe_o !== '0 || busy !== 1'b0 || state !== RUN) begin
      errors++;
      $display("FAIL reset_state: valid=%0b sbe_zero=%0b busy=%0b state=%0d, expected 0/1/0/0",
               bus.issue_valid_o, bus.issue_sbe_o == '0, busy, state);
    end
    step();
    checks++;
    if (bus.fetch_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: fetch_ready=%0b, expected 1", bus.fetch_ready_o);
    end
  endtask

  task automatic test_stream();
    do_reset();
    bus.issue_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_push(32'h100 + 32'(4 * i), I_ADDI);
      else       idle_fetch();
      step();
      checks++;
      if (i == 0) begin
        if (bus.issue_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL stream_latency: valid=%0b one cycle after push, expected 0", bus.issue_valid_o);
        end
      end else if (bus.issue_valid_o !== 1'b1 || bus.issue_sbe_o.trans_id !== 3'(i - 1) ||
                   bus.issue_sbe_o.pc !== 32'h100 + 32'(4 * (i - 1)) || bus.issue_sbe_o.fu !== FU_ALU) begin
        errors++;
        $display("FAIL stream_issue[%0d]: valid=%0b tid=%0d pc=%h fu=%0d, expected 1 tid=%0d pc=%h fu=%0d",
                 i, bus.issue_valid_o, bus.issue_sbe_o.trans_id, bus.issue_sbe_o.pc,
                 bus.issue_sbe_o.fu, i - 1, 32'h100 + 32'(4 * (i - 1)), FU_ALU);
      end
    end
    step();
    checks++;
    if (bus.issue_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: valid=%0b, expected 0", bus.issue_valid_o);
    end
  endtask

  task automatic test_wrap_backpressure();
    do_reset();
    bus.issue_ack_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) drive_push(32'h1000 + 32'(4 * i), I_ADDI);
      else       idle_fetch();
      step();
      if (i >= 1) begin
        checks++;
        if (bus.issue_valid_o !== 1'b1 || bus.issue_sbe_o.trans_id !== 3'((i - 1) % 8) ||
            bus.issue_sbe_o.pc !== 32'h1000 + 32'(4 * (i - 1))) begin
          errors++;
          $display("FAIL wrap_issue[%0d]: valid=%0b tid=%0d pc=%h, expected 1 tid=%0d pc=%h",
                   i, bus.issue_valid_o, bus.issue_sbe_o.trans_id, bus.issue_sbe_o.pc,
                   (i - 1) % 8, 32'h1000 + 32'(4 * (i - 1)));
        end
      end
    end
    step();
    // Index counter now sits at 1 after nine loads.
    bus.issue_ack_i = 1'b0;
    drive_push(32'h200, I_ADDI);
    step();
    drive_push(32'h204, I_ADDI);
    step();
    drive_push(32'h208, I_ADDI);
    step();
    drive_push(32'h20C, I_ADDI);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.fetch_ready_o !== 1'b0 || bus.issue_valid_o !== 1'b1 ||
          bus.issue_sbe_o.pc !== 32'h200 || bus.issue_sbe_o.trans_id !== 3'd1) begin
        errors++;
        $display("FAIL hold[%0d]: ready=%0b valid=%0b pc=%h tid=%0d, expected 0 1 00000200 1",
                 k, bus.fetch_ready_o, bus.issue_valid_o, bus.issue_sbe_o.pc, bus.issue_sbe_o.trans_id);
      end
      step();
    end
    idle_fetch();
    bus.issue_ack_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (k < 2) begin
        if (bus.issue_valid_o !== 1'b1 || bus.issue_sbe_o.pc !== 32'h204 + 32'(4 * k) ||
            bus.issue_sbe_o.trans_id !== 3'(2 + k)) begin
          errors++;
          $display("FAIL release[%0d]: valid=%0b pc=%h tid=%0d, expected 1 pc=%h tid=%0d",
                   k, bus.issue_valid_o, bus.issue_sbe_o.pc, bus.issue_sbe_o.trans_id,
                   32'h204 + 32'(4 * k), 2 + k);
        end
      end else if (bus.issue_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL release_end: valid=%0b, expected 0 (blocked push must be dropped)", bus.issue_valid_o);
      end
    end
  endtask

  task automatic test_serialize();
    do_reset();
    drive_push(32'h300, I_CSRRW);
    step();
    drive_push(32'h304, I_ADD);
    step();
    checks++;
    if (bus.issue_valid_o !== 1'b1 || bus.issue_sbe_o.fu !== FU_CSR || bus.issue_sbe_o.trans_id !== 3'd0 ||
        busy !== 1'b1 || state !== SERIAL || bus.fetch_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL serial_enter: valid=%0b fu=%0d tid=%0d busy=%0b state=%0d ready=%0b, expected 1 %0d 0 1 %0d 1",
               bus.issue_valid_o, bus.issue_sbe_o.fu, bus.issue_sbe_o.trans_id, busy, state,
               bus.fetch_ready_o, FU_CSR, SERIAL);
    end
    idle_fetch();
    serialize_done = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1 || bus.issue_valid_o !== 1'b1 || bus.issue_sbe_o.pc !== 32'h300) begin
      errors++;
      $display("FAIL serial_early_done: busy=%0b valid=%0b pc=%h, expected 1 1 00000300",
               busy, bus.issue_valid_o, bus.issue_sbe_o.pc);
    end
    serialize_done = 1'b0;
    bus.issue_ack_i = 1'b1;
    step();
    checks++;
    if (bus.issue_valid_o !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL serial_acked: valid=%0b busy=%0b, expected 0 1", bus.issue_valid_o, busy);
    end
    bus.issue_ack_i = 1'b0;
    serialize_done = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || bus.issue_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL serial_exit: busy=%0b valid=%0b, expected 0 0", busy, bus.issue_valid_o);
    end
    serialize_done = 1'b0;
    step();
    checks++;
    if (bus.issue_valid_o !== 1'b1 || bus.issue_sbe_o.pc !== 32'h304 || bus.issue_sbe_o.trans_id !== 3'd1 ||
        bus.issue_sbe_o.fu !== FU_ALU || bus.issue_sbe_o.op !== OP_ADD) begin
      errors++;
      $display("FAIL serial_next: valid=%0b pc=%h tid=%0d fu=%0d op=%0d, expected 1 00000304 1 %0d %0d",
               bus.issue_valid_o, bus.issue_sbe_o.pc, bus.issue_sbe_o.trans_id, bus.issue_sbe_o.fu,
               bus.issue_sbe_o.op, FU_ALU, OP_ADD);
    end
  endtask

  task automatic test_illegal_halt();
    do_reset();
    bus.issue_ack_i = 1'b1;
    drive_push(32'h400, I_BAD);
    step();
    drive_push(32'h404, I_ADDI);
    step();
    checks++;
    if (bus.issue_valid_o !== 1'b1 || bus.issue_sbe_o.ex.valid !== 1'b1 ||
        bus.issue_sbe_o.ex.cause !== ILLEGAL_INSTR || bus.issue_sbe_o.ex.tval !== 32'hFFFFFFFF ||
        state !== HALT || busy !== 1'b1) begin
      errors++;
      $display("FAIL illegal_ex: valid=%0b ex={%0b,%0d,%h} state=%0d busy=%0b, expected 1 {1,%0d,ffffffff} %0d 1",
               bus.issue_valid_o, bus.issue_sbe_o.ex.valid, bus.issue_sbe_o.ex.cause,
               bus.issue_sbe_o.ex.tval, state, busy, ILLEGAL_INSTR, HALT);
    end
    idle_fetch();
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (bus.issue_valid_o !== 1'b0 || state !== HALT) begin
        errors++;
        $display("FAIL halt_hold[%0d]: valid=%0b state=%0d, expected 0 %0d", k, bus.issue_valid_o, state, HALT);
      end
    end
    flush = 1'b1;
    #1;
    checks++;
    if (bus.fetch_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: fetch_ready=%0b during flush, expected 0", bus.fetch_ready_o);
    end
    step();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || state !== RUN || bus.issue_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_halt: busy=%0b state=%0d valid=%0b, expected 0 %0d 0", busy, state, bus.issue_valid_o, RUN);
    end
    step();
    checks++;
    if (bus.issue_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: valid=%0b, expected 0", bus.issue_valid_o);
    end
    drive_push(32'h500, I_ADDI);
    step();
    idle_fetch();
    step();
    checks++;
    if (bus.issue_valid_o !== 1'b1 || bus.issue_sbe_o.pc !== 32'h500 || bus.issue_sbe_o.trans_id !== 3'd0) begin
      errors++;
      $display("FAIL flush_idx: valid=%0b pc=%h tid=%0d, expected 1 00000500 0",
               bus.issue_valid_o, bus.issue_sbe_o.pc, bus.issue_sbe_o.trans_id);
    end
  endtask

  task automatic test_flush_collision();
    do_reset();
    bus.issue_ack_i = 1'b1;
    drive_push(32'h600, I_ADDI);
    step();
    drive_push(32'h604, I_ADDI);
    step();
    checks++;
    if (bus.issue_valid_o !== 1'b1 || bus.issue_sbe_o.trans_id !== 3'd0) begin
      errors++;
      $display("FAIL collide_pre: valid=%0b tid=%0d, expected 1 0", bus.issue_valid_o, bus.issue_sbe_o.trans_id);
    end
    flush = 1'b1;
    drive_push(32'h608, I_ADDI);
    step();
    flush = 1'b0;
    idle_fetch();
    checks++;
    if (bus.issue_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL collide_flush: valid=%0b, expected 0", bus.issue_valid_o);
    end
    step();
    checks++;
    if (bus.issue_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL collide_nopush: valid=%0b, expected 0", bus.issue_valid_o);
    end
    drive_push(32'h60C, I_ADDI);
    step();
    idle_fetch();
    step();
    checks++;
    if (bus.issue_valid_o !== 1'b1 || bus.issue_sbe_o.pc !== 32'h60C || bus.issue_sbe_o.trans_id !== 3'd0) begin
      errors++;
      $display("FAIL collide_idx: valid=%0b pc=%h tid=%0d, expected 1 0000060c 0",
               bus.issue_valid_o, bus.issue_sbe_o.pc, bus.issue_sbe_o.trans_id);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h700 + 32'(4 * i), I_ADDI);
      step();
    end
    checks++;
    if (bus.fetch_ready_o !== 1'b0 || bus.issue_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_full: ready=%0b valid=%0b, expected 0 1", bus.fetch_ready_o, bus.issue_valid_o);
    end
    rst_n = 1'b0;
    step();
    idle_fetch();
    checks++;
    if (bus.issue_valid_o !== 1'b0 || bus.issue_sbe_o !== '0 || busy !== 1'b0 ||
        state !== RUN || bus.fetch_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%0b sbe_zero=%0b busy=%0b state=%0d ready=%0b, expected 0 1 0 0 1",
               bus.issue_valid_o, bus.issue_sbe_o == '0, busy, state, bus.fetch_ready_o);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.issue_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_empty: valid=%0b, expected 0", bus.issue_valid_o);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    priv_lvl   = PRIV_M;
    debug_mode = 1'b0;
    tvm        = 1'b0;
    tw         = 1'b0;
    tsr        = 1'b0;
    serialize_done  = 1'b0;
    bus.issue_ack_i = 1'b0;
    idle_fetch();

    test_reset();
    test_stream();
    test_wrap_backpressure();
    test_serialize();
    test_illegal_halt();
    test_flush_collision();
    test_mid_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
